// File: rtl/pipeline_pkg.sv
// Shared constants and types for the MISC-V pipeline control slice.
package pipeline_pkg;

    // Register-file index width and machine word width.
    localparam int REG_ADDR_W = 4;
    localparam int DATA_W     = 16;

    // Sequencer states.
    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/pipeline_control_hazard_detect.sv
// Load-use hazard compare: the instruction in ID reads a register that the
// load currently in EX has not yet produced. Kept separate so a forwarding
// unit can reuse the same compare.
module hazard_detect #(
    parameter int REG_ADDR_W = pipeline_pkg::REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic                  uses_rs1,
    input  logic                  uses_rs2,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  load_use
);

    // Index 0 is deliberately treated like any other register.
    always_comb begin
        load_use = ex_mem_read &
                   ((uses_rs1 & (rs1 == ex_rd)) | (uses_rs2 & (rs2 == ex_rd)));
    end

endmodule

// File: rtl/pipeline_control.sv
// Hazard and sequencing controller for the five-stage pipeline: post-reset
// flush sequence, memory-wait freeze with timeout, branch flush, load-use
// stall, plus a saturating stall counter and a sticky memory-error flag.
module pipeline_control #(
    parameter int REG_ADDR_W  = pipeline_pkg::REG_ADDR_W,
    parameter int INIT_CYCLES = 4,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                            CLK,
    input  logic                            Reset,
    input  logic [REG_ADDR_W-1:0]           IDRs1,
    input  logic [REG_ADDR_W-1:0]           IDRs2,
    input  logic                            IDUsesRs1,
    input  logic                            IDUsesRs2,
    input  logic                            EXMemRead,
    input  logic [REG_ADDR_W-1:0]           EXRd,
    input  logic                            EXBranchTaken,
    input  logic                            MemReq,
    input  logic                            MemReady,
    output logic                            PCWrite,
    output logic                            IFIDWrite,
    output logic                            IDEXWrite,
    output logic                            EXMEMWrite,
    output logic                            MEMWBWrite,
    output logic                            IFIDFlush,
    output logic                            IDEXFlush,
    output logic                            EXMEMFlush,
    output logic                            MEMWBFlush,
    output logic                            Busy,
    output logic                            MemError,
    output logic [pipeline_pkg::DATA_W-1:0] StallCount
);

    import pipeline_pkg::*;

    localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int WAIT_W = $clog2(MEM_TIMEOUT);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t              state;
    state_t              state_next;
    logic [INIT_W-1:0]   init_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                force_rel;
    logic                load_use;
    logic                mem_wait;
    logic                timeout;

    // Saturating increment for the stall counter.
    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
        return (v == {DATA_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard (
        .rs1         (IDRs1),
        .rs2         (IDRs2),
        .uses_rs1    (IDUsesRs1),
        .uses_rs2    (IDUsesRs2),
        .ex_mem_read (EXMemRead),
        .ex_rd       (EXRd),
        .load_use    (load_use)
    );

    // Mealy control: stage enables/flushes by priority, plus next state.
    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IDEXWrite  = 1'b1;
        EXMEMWrite = 1'b1;
        MEMWBWrite = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXFlush  = 1'b0;
        EXMEMFlush = 1'b0;
        MEMWBFlush = 1'b0;
        state_next = state;

        Busy = Reset || (state == S_INIT);
        // The cycle after a timeout behaves as if memory had answered.
        mem_wait = MemReq & ~MemReady & ~force_rel;
        timeout  = mem_wait && (wait_cnt == WAIT_LAST);

        if (Busy) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXWrite  = 1'b0;
            EXMEMWrite = 1'b0;
            MEMWBWrite = 1'b0;
            IFIDFlush  = 1'b1;
            IDEXFlush  = 1'b1;
            EXMEMFlush = 1'b1;
            MEMWBFlush = 1'b1;
        end else if (mem_wait) begin
            // Freeze everything up to EX_MEM; feed a bubble into WB.
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXWrite  = 1'b0;
            EXMEMWrite = 1'b0;
            MEMWBFlush = 1'b1;
        end else if (EXBranchTaken) begin
            // Squash the two wrong-path instructions behind the branch.
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
        end else if (load_use) begin
            // Hold IF/ID for one cycle and insert a bubble into EX.
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
        end

        case (state)
            S_INIT:  state_next = (init_cnt == INIT_LAST) ? S_RUN : S_INIT;
            S_RUN,
            S_WAIT:  state_next = mem_wait ? S_WAIT : S_RUN;
            default: state_next = S_INIT;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= S_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Init/wait counters, timeout release, error flag and stall statistics.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            init_cnt   <= '0;
            wait_cnt   <= '0;
            force_rel  <= 1'b0;
            MemError   <= 1'b0;
            StallCount <= '0;
        end else if (state == S_INIT) begin
            if (init_cnt != INIT_LAST) begin
                init_cnt <= init_cnt + 1'b1;
            end
        end else begin
            force_rel <= timeout;
            if (timeout) begin
                MemError <= 1'b1;
                wait_cnt <= '0;
            end else if (mem_wait) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (!PCWrite) begin
                StallCount <= sat_inc(StallCount);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_control.sv
// Scoreboard bench for pipeline_control: the driver computes the expected
// outputs of every cycle from a cycle-count model and queues them; a monitor
// on the falling edge pops and compares against the DUT.
module tb_pipeline_control;

    localparam int RW          = 4;
    localparam int INIT_CYCLES = 4;
    localparam int MEM_TIMEOUT = 64;

    logic          CLK = 1'b0;
    logic          Reset = 1'b1;
    logic [RW-1:0] IDRs1 = '0;
    logic [RW-1:0] IDRs2 = '0;
    logic          IDUsesRs1 = 1'b0;
    logic          IDUsesRs2 = 1'b0;
    logic          EXMemRead = 1'b0;
    logic [RW-1:0] EXRd = '0;
    logic          EXBranchTaken = 1'b0;
    logic          MemReq = 1'b0;
    logic          MemReady = 1'b0;
    logic          PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite;
    logic          IFIDFlush, IDEXFlush, EXMEMFlush, MEMWBFlush;
    logic          Busy, MemError;
    logic [15:0]   StallCount;

    pipeline_control #(
        .REG_ADDR_W  (RW),
        .INIT_CYCLES (INIT_CYCLES),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .CLK           (CLK),
        .Reset         (Reset),
        .IDRs1         (IDRs1),
        .IDRs2         (IDRs2),
        .IDUsesRs1     (IDUsesRs1),
        .IDUsesRs2     (IDUsesRs2),
        .EXMemRead     (EXMemRead),
        .EXRd          (EXRd),
        .EXBranchTaken (EXBranchTaken),
        .MemReq        (MemReq),
        .MemReady      (MemReady),
        .PCWrite       (PCWrite),
        .IFIDWrite     (IFIDWrite),
        .IDEXWrite     (IDEXWrite),
        .EXMEMWrite    (EXMEMWrite),
        .MEMWBWrite    (MEMWBWrite),
        .IFIDFlush     (IFIDFlush),
        .IDEXFlush     (IDEXFlush),
        .EXMEMFlush    (EXMEMFlush),
        .MEMWBFlush    (MEMWBFlush),
        .Busy          (Busy),
        .MemError      (MemError),
        .StallCount    (StallCount)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          idx;
        logic [26:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   done = 1'b0;

    // Reference state: cycles of INIT left, length of the current memory
    // wait, pending forced release, stall total and sticky error.
    int m_init_left = INIT_CYCLES;
    int m_wait_len  = 0;
    bit m_force     = 1'b0;
    int m_stall     = 0;
    bit m_err       = 1'b0;

    // One clock cycle: apply inputs, queue the expected response, advance model.
    task automatic step(input bit rst, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                        input bit u1, input bit u2, input bit mrd, input logic [RW-1:0] rd,
                        input bit br, input bit req, input bit rdy);
        bit       busy, mw, lu;
        bit [8:0] c;  // PC,IFID,IDEX,EXMEM,MEMWB writes then IFID,IDEX,EXMEM,MEMWB flushes
        exp_t     e;
        @(posedge CLK);
        #1;
        Reset = rst; IDRs1 = rs1; IDRs2 = rs2; IDUsesRs1 = u1; IDUsesRs2 = u2;
        EXMemRead = mrd; EXRd = rd; EXBranchTaken = br; MemReq = req; MemReady = rdy;

        busy = rst || (m_init_left > 0);
        mw   = req && !rdy && !m_force;
        lu   = mrd && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        if (busy)      c = 9'b00000_1111;
        else if (mw)   c = 9'b00001_0001;
        else if (br)   c = 9'b11111_1100;
        else if (lu)   c = 9'b00111_0100;
        else           c = 9'b11111_0000;
        e.idx = cyc;
        e.v   = {c, busy, m_err, 16'(m_stall)};
        sb.push_back(e);
        cyc++;

        if (rst) begin
            m_init_left = INIT_CYCLES;
            m_wait_len  = 0;
            m_force     = 1'b0;
            m_stall     = 0;
            m_err       = 1'b0;
        end else if (m_init_left > 0) begin
            m_init_left--;
        end else begin
            if (!c[8] && m_stall < 65535) m_stall++;
            if (mw && m_wait_len == MEM_TIMEOUT - 1) begin
                m_err      = 1'b1;
                m_force    = 1'b1;
                m_wait_len = 0;
            end else begin
                m_force    = 1'b0;
                m_wait_len = mw ? m_wait_len + 1 : 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare each queued expectation, then the final drain check.
    always @(negedge CLK) begin : mon
        exp_t        e;
        logic [26:0] act;
        if (sb.size() != 0) begin
            e   = sb.pop_front();
            act = {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite,
                   IFIDFlush, IDEXFlush, EXMEMFlush, MEMWBFlush, Busy, MemError, StallCount};
            n_cmp++;
            if (act !== e.v) begin
                n_bad++;
                $display("FAIL cycle %0d outputs: got %h expected %h", e.idx, act, e.v);
            end
        end else if (done) begin
            n_cmp++;
            if (cyc < 100) begin
                n_bad++;
                $display("FAIL stimulus_count: got %0d expected at least 100", cyc);
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    // Hard time bound so the run can never hang.
    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    // Stimulus.
    initial begin
        int hold;
        // Reset two cycles, then the INIT flush sequence and plain RUN.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(8);
        // Load-use on Rs2.
        step(0, 0, 3, 0, 1, 1, 3, 0, 0, 0);
        idle(2);
        // Load-use together with a taken branch.
        step(0, 0, 3, 0, 1, 1, 3, 1, 0, 0);
        idle(2);
        // Five-cycle memory wait then completion.
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(2);
        // Memory stuck for 70 cycles: timeout, forced release, sticky error.
        for (int i = 0; i < 70; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(4);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(6);
        // Reset in the middle of a wait.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(6);
        // Randomised traffic with occasional resets and stuck memory.
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            bit rst, req, rdy;
            rst = ($urandom_range(0, 299) == 0);
            req = ($urandom_range(0, 2) != 0);
            if (hold == 0 && $urandom_range(0, 399) == 0) hold = 70;
            if (hold > 0) begin
                req = 1'b1;
                rdy = 1'b0;
                hold--;
            end else begin
                rdy = ($urandom_range(0, 3) != 0);
            end
            step(rst, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
                 ($urandom_range(0, 5) == 0), req, rdy);
        end
        // Stall counter saturation via a long run of load-use stalls.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(5);
        for (int i = 0; i < 65540; i++) step(0, 0, 3, 0, 1, 1, 3, 0, 0, 0);
        idle(3);
        step(0, 5, 0, 1, 0, 1, 5, 0, 0, 0);
        idle(2);
        done = 1'b1;
    end

endmodule

// File: doc/pipeline_control.md
Name: pipeline_control

Overview:
Central hazard and sequencing controller for the 16-bit MISC-V five-stage pipeline. It drives the write-enable and flush inputs of the PC and of the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers. It resolves three cases:
- load-use stalls;
- taken-branch/jump flushes;
- multi-cycle data-memory waits, with a timeout.

After reset it runs a fixed flush sequence and maintains a stall performance counter.

Parameters:
REG_ADDR_W, 4, register-index width.
INIT_CYCLES, 4, number of cycles all stages are flushed after Reset deasserts (must be ≥1).
MEM_TIMEOUT, 64, maximum consecutive memory-wait cycles before a forced release (must be ≥2).

Ports:
CLK  in  1  clock, rising edge.
Reset  in  1  synchronous, active-high reset.
IDRs1  in  REG_ADDR_W  source 1 index of the instruction in ID.
IDRs2  in  REG_ADDR_W  source 2 index of the instruction in ID.
IDUsesRs1  in  1  the ID instruction reads Rs1.
IDUsesRs2  in  1  the ID instruction reads Rs2.
EXMemRead  in  1  the instruction in EX is a load.
EXRd  in  REG_ADDR_W  destination index of the instruction in EX.
EXBranchTaken  in  1  the EX instruction redirects the PC this cycle.
MemReq  in  1  the EX_MEM stage holds a memory access (OMemRead|OMemWrite).
MemReady  in  1  data memory completes the access this cycle.
PCWrite  out  1  PC update enable.
IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite  out  1 each  stage register enables.
IFIDFlush, IDEXFlush, EXMEMFlush, MEMWBFlush  out  1 each  stage register clear (bubble) requests.
Busy  out  1  high during the INIT state.
MemError  out  1  sticky flag, set on memory timeout.
StallCount  out  16  number of cycles in which PCWrite was 0 during RUN or WAIT; saturates at 0xFFFF.

Behaviour:
- Registered state: INIT, RUN, WAIT. Registered counters: init counter, wait counter, StallCount, and MemError.
- Reset (synchronous) values:
  - state = INIT, init counter = 0, wait counter = 0, StallCount = 0, MemError = 0.
  - Outputs during Reset and INIT: all Write = 0, all Flush = 1, Busy = 1.
- INIT:
  - Lasts exactly INIT_CYCLES cycles after the first clock edge with Reset low, then moves to RUN.
  - StallCount does not increment.
- Control outputs are combinational from the current state and inputs (Mealy), so a hazard acts in the same cycle it appears.
- Derived terms:
  - memwait = MemReq & ~MemReady.
  - loaduse = EXMemRead & ((IDUsesRs1 & IDRs1 == EXRd) | (IDUsesRs2 & IDRs2 == EXRd)).
  - Index 0 is not special-cased.
- Priority in RUN/WAIT, highest first:
  1. memwait:
     - PC, IF_ID, ID_EX and EX_MEM are frozen (Write = 0).
     - MEMWBWrite = 1 and MEMWBFlush = 1 (bubble into WB).
     - All other flushes = 0.
     - Branch and load-use are ignored; they are re-evaluated after release.
  2. EXBranchTaken:
     - All Write = 1.
     - IFIDFlush = 1 and IDEXFlush = 1; EXMEMFlush and MEMWBFlush = 0.
     - Load-use in the same cycle is discarded.
  3. loaduse:
     - PCWrite = 0, IFIDWrite = 0, IDEXWrite = 1 with IDEXFlush = 1 (bubble).
     - EXMEMWrite = 1 and MEMWBWrite = 1; no other flushes.
  4. Otherwise: all Write = 1, all Flush = 0.
- State transitions:
  - RUN → WAIT when memwait.
  - WAIT → RUN when MemReady (freeze released in that same cycle).
- Wait counter:
  - Counts consecutive memwait cycles and clears in RUN.
  - When it reaches MEM_TIMEOUT−1 while memwait persists:
    - MemError is set.
    - The next cycle is treated as MemReady: forced release, EX_MEM advances, state → RUN.
  - MemError is cleared only by Reset.
- Reset asserted mid-WAIT or mid-stall: the next edge enters INIT and drops all counters; no pending hazard is remembered.
- StallCount increments on every RUN/WAIT cycle with PCWrite = 0 and holds at 0xFFFF.

Decomposition:
- Shared package pipeline_pkg holds:
  - state encoding constants (INIT = 2'd0, RUN = 2'd1, WAIT = 2'd2);
  - REG_ADDR_W;
  - the 16-bit datapath width constant.
- One natural sub-module, hazard_detect: purely combinational loaduse compare, reusable by a forwarding unit.
- Counters and the FSM stay in pipeline_control.

Test Plan:
- Reset high 2 cycles, then low → Busy = 1 and all Flush = 1 for exactly 4 cycles; then RUN with all Write = 1, all Flush = 0, StallCount = 0.
- RUN; EXMemRead = 1, EXRd = 3, IDRs2 = 3, IDUsesRs2 = 1 for 1 cycle → PCWrite = 0, IFIDWrite = 0, IDEXFlush = 1 that cycle; StallCount = 1 afterwards.
- Same load-use stimulus plus EXBranchTaken = 1 → IFIDFlush = IDEXFlush = 1, PCWrite = 1, StallCount unchanged.
- MemReq = 1, MemReady = 0 for 5 cycles, then MemReady = 1 → PC/IF_ID/ID_EX/EX_MEM frozen for 5 cycles with MEMWBFlush = 1; release on cycle 6; StallCount += 5; MemError = 0.
- MemReq = 1, MemReady = 0 held 70 cycles → forced release after 64 cycles, MemError = 1 and sticky, state back to RUN; Reset clears MemError.
- Reset asserted during WAIT → next cycle Busy = 1, counters = 0; StallCount saturation checked by preloading via 65540 load-use stalls → value holds at 0xFFFF.
